exmem_skid_stage: RTL and testbench



---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_payload_reg.sv | 20 ++
 rtl/exmem_skid_stage.sv | 142 ++++++++++++++
 tb/tb_exmem_skid_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the EX/MEM pipeline stage: FSM state encoding,
// control-bit positions and default path widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMREAD  = 2;
    localparam int CTRL_MEMWRITE = 3;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_W   = 5;
    localparam int DEF_CTRL_W = 4;

endpackage

// File: rtl/pipe_payload_reg.sv
// Width-parametrised payload register with load enable and async clear to zero.
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline stage with a two-entry skid buffer, flush and bubble gating.
// Optional saturating MEM-stall counter port when EXMEM_STALL_CNT_EN is defined.
module exmem_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_W   = DEF_RD_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [RD_W-1:0]   rd_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [RD_W-1:0]   rd_o,
    output logic [DATA_W-1:0] alu_o,
    output logic [1:0]        state_o,
    output logic [DATA_W-1:0] wdata_o
`ifdef EXMEM_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam int PW = CTRL_W + RD_W + 2 * DATA_W;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and in_ready_o is a flop.
    state_t        state;
    state_t        next_state;
    logic          in_ready_q;
    logic          in_fire;
    logic          out_fire;
    logic          out_valid;
    logic          main_load;
    logic          skid_load;
    logic [PW-1:0] in_payload;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;

    assign in_payload = {ctrl_i, rd_i, alu_i, wdata_i};
    assign out_valid  = (state != EMPTY);
    assign in_fire    = in_valid_i & in_ready_q;
    assign out_fire   = out_valid & out_ready_i;

    always_comb begin
        next_state = state;
        main_load  = 1'b0;
        skid_load  = 1'b0;
        main_d     = in_payload;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    next_state = BUSY;
                    main_load  = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_load = 1'b1;
                end else if (in_fire) begin
                    next_state = FULL;
                    skid_load  = 1'b1;
                end else if (out_fire) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    next_state = BUSY;
                    main_load  = 1'b1;
                    main_d     = skid_q;
                end
            end
            default: next_state = EMPTY;
        endcase
        // Flush discards everything, and loads nothing so the flushed input
        // never shows up on the held payload outputs either.
        if (flush_i) begin
            next_state = EMPTY;
            main_load  = 1'b0;
            skid_load  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= next_state;
            in_ready_q <= (next_state != FULL);
        end
    end

    pipe_payload_reg #(.W(PW)) u_main (
        .clk  (clk_i),
        .rst  (rst_i),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_payload_reg #(.W(PW)) u_skid (
        .clk  (clk_i),
        .rst  (rst_i),
        .load (skid_load),
        .d    (in_payload),
        .q    (skid_q)
    );

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid;
    assign state_o     = state;
    assign ctrl_o      = out_valid ? main_q[PW-1 -: CTRL_W] : '0;
    assign rd_o        = main_q[2*DATA_W +: RD_W];
    assign alu_o       = main_q[DATA_W +: DATA_W];
    assign wdata_o     = main_q[0 +: DATA_W];

`ifdef EXMEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready_i && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Directed bench for exmem_skid_stage: queue-based reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_exmem_skid_stage;
    import pipe_pkg::*;

    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int CTRL_W = 4;
    localparam int PW     = CTRL_W + RD_W + 2 * DATA_W;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              flush     = 1'b0;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] ctrl_in   = '0;
    logic [RD_W-1:0]   rd_in     = '0;
    logic [DATA_W-1:0] alu_in    = '0;
    logic [DATA_W-1:0] wdata_in  = '0;
    logic              in_ready;
    logic              out_valid;
    logic [CTRL_W-1:0] ctrl_out;
    logic [RD_W-1:0]   rd_out;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] wdata_out;
    logic [1:0]        state_out;
`ifdef EXMEM_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    exmem_skid_stage #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .ctrl_i      (ctrl_in),
        .rd_i        (rd_in),
        .alu_i       (alu_in),
        .wdata_i     (wdata_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .ctrl_o      (ctrl_out),
        .rd_o        (rd_out),
        .alu_o       (alu_out),
        .state_o     (state_out),
        .wdata_o     (wdata_out)
`ifdef EXMEM_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: accepted-but-not-consumed items, oldest first
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] m_last     = '0;
    logic          m_in_ready = 1'b1;
    logic [31:0]   m_stall    = '0;

    task automatic model_reset();
        exp_q.delete();
        m_last     = '0;
        m_in_ready = 1'b1;
        m_stall    = '0;
    endtask

    // Advance the model by one clock edge using the inputs held for that edge.
    task automatic model_step();
        logic in_f;
        logic out_f;
        in_f  = in_valid && m_in_ready;
        out_f = (exp_q.size() != 0) && out_ready;
        if (exp_q.size() != 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        if (out_f) void'(exp_q.pop_front());
        if (flush) exp_q.delete();
        else if (in_f) exp_q.push_back({ctrl_in, rd_in, alu_in, wdata_in});
        if (exp_q.size() != 0) m_last = exp_q[0];
        m_in_ready = (exp_q.size() < 2);
    endtask

    // scoreboard: compare on every falling edge, then advance for the next rising edge
    initial begin
        forever begin
            logic          v;
            logic [1:0]    st;
            @(negedge clk);
            if (rst) model_reset();
            v  = (exp_q.size() != 0);
            st = (exp_q.size() == 0) ? EMPTY : (exp_q.size() == 1) ? BUSY : FULL;
            check("out_valid", out_valid, v);
            check("in_ready", in_ready, m_in_ready);
            check("ctrl_o", ctrl_out, v ? m_last[PW-1 -: CTRL_W] : '0);
            check("rd_o", rd_out, m_last[2*DATA_W +: RD_W]);
            check("alu_o", alu_out, m_last[DATA_W +: DATA_W]);
            check("wdata_o", wdata_out, m_last[0 +: DATA_W]);
            check("state", state_out, st);
`ifdef EXMEM_STALL_CNT_EN
            check("stall_cnt", stall_cnt, m_stall);
`endif
            if (!rst) model_step();
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] a);
        in_valid = v;
        ctrl_in  = c;
        alu_in   = a;
        rd_in    = a[RD_W-1:0] ^ 5'h15;
        wdata_in = a ^ 32'hA5A5_0000;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", out_valid, 1'b0);
        check("reset in_ready", in_ready, 1'b1);
        check("reset alu_o", alu_out, 32'h0);
        check("reset ctrl_o", ctrl_out, 4'h0);
        rst = 1'b0;

        // stream four items at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 4'b0001, 32'(i));
            step();
            check("stream alu_o", alu_out, 32'(i));
            check("stream valid", out_valid, 1'b1);
            check("stream in_ready", in_ready, 1'b1);
        end
        drive(1'b0, 4'b0000, 32'h0);
        step();
        check("drain valid", out_valid, 1'b0);
        check("drain alu hold", alu_out, 32'h4);

        // back-pressure: A held, B lands in the skid entry
        out_ready = 1'b0;
        drive(1'b1, 4'b1001, 32'hA);
        step();
        check("bp busy alu", alu_out, 32'hA);
        drive(1'b1, 4'b1001, 32'hB);
        step();
        check("bp full in_ready", in_ready, 1'b0);
        check("bp full alu", alu_out, 32'hA);
        drive(1'b0, 4'b1001, 32'hC);
        step();
        check("bp hold alu", alu_out, 32'hA);
        check("bp hold ctrl", ctrl_out, 4'b1001);
        out_ready = 1'b1;
        step();
        check("bp release alu", alu_out, 32'hB);
        check("bp release in_ready", in_ready, 1'b1);
        step();

        // bubble: stale ctrl must not leak, payload holds
        check("bubble valid", out_valid, 1'b0);
        check("bubble ctrl", ctrl_out, 4'b0000);
        check("bubble alu hold", alu_out, 32'hB);
        check("bubble rd hold", rd_out, 5'hB ^ 5'h15);

        // flush while FULL with a valid input in the same cycle
        out_ready = 1'b0;
        drive(1'b1, 4'b1001, 32'h10);
        step();
        drive(1'b1, 4'b1001, 32'h11);
        step();
        check("pre-flush in_ready", in_ready, 1'b0);
        flush = 1'b1;
        drive(1'b1, 4'b1001, 32'h12);
        step();
        flush = 1'b0;
        drive(1'b0, 4'b0000, 32'h0);
        check("flush valid", out_valid, 1'b0);
        check("flush in_ready", in_ready, 1'b1);
        check("flush ctrl", ctrl_out, 4'h0);
        check("flush alu hold", alu_out, 32'h10);
        out_ready = 1'b1;
        repeat (2) step();
        check("post-flush valid", out_valid, 1'b0);

        // async reset mid-cycle while FULL
        out_ready = 1'b0;
        drive(1'b1, 4'b0001, 32'h20);
        step();
        drive(1'b1, 4'b0001, 32'h21);
        step();
        drive(1'b0, 4'b0000, 32'h0);
        #2 rst = 1'b1;
        #1;
        check("async valid", out_valid, 1'b0);
        check("async in_ready", in_ready, 1'b1);
        check("async alu", alu_out, 32'h0);
        check("async wdata", wdata_out, 32'h0);
        check("async rd", rd_out, 5'h0);
        check("async ctrl", ctrl_out, 4'h0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 4'b0001, 32'h30);
        step();
        check("restart alu", alu_out, 32'h30);
        drive(1'b0, 4'b0000, 32'h0);
        step();

`ifdef EXMEM_STALL_CNT_EN
        // seven stalled cycles, then flush with MEM consuming
        out_ready = 1'b0;
        drive(1'b1, 4'b0001, 32'h40);
        step();
        drive(1'b0, 4'b0000, 32'h0);
        repeat (7) step();
        check("stall count", stall_cnt, 32'd7);
        flush     = 1'b1;
        out_ready = 1'b1;
        step();
        flush = 1'b0;
        check("stall after flush", stall_cnt, 32'd7);
        step();
`endif

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
